// File: rtl/dff_delay_line.sv
// dff_delay_line: stallable DEPTH-stage WIDTH-bit delay line with valid tracking, flush and registered occupancy.
// Ports: clk, rst (sync, active-high), en (advance), d/d_valid (stage-0 input), flush (invalidate all),
//        q/q_valid (last stage), occupancy (count of valid stages).
module dff_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [WIDTH-1:0]             d,
  input  logic                         d_valid,
  input  logic                         flush,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int OW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] stage [DEPTH];
  logic [DEPTH-1:0] valid, valid_nxt;
  logic [OW-1:0]    count_nxt;
  // occupancy is the popcount of the next valid vector so it lands on the same edge as the bits it counts
  always_comb begin
    valid_nxt = valid;
    if (en) begin
      valid_nxt[0] = d_valid;
      for (int i = 1; i < DEPTH; i++) valid_nxt[i] = valid[i-1];
    end
    if (flush) valid_nxt = '0;
    count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) count_nxt = count_nxt + OW'(valid_nxt[i]);
  end
  // flush leaves data untouched; only the valid bits are cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      valid     <= '0;
      occupancy <= '0;
    end else begin
      if (en && !flush) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
      valid     <= valid_nxt;
      occupancy <= count_nxt;
    end
  end
  assign q       = stage[DEPTH-1];
  assign q_valid = valid[DEPTH-1];
endmodule

// File: tb/tb_dff_delay_line.sv
// tb_dff_delay_line: randomized and directed checks of dff_delay_line against a queue-based history model.
module tb_dff_delay_line;
  logic       clk = 0;
  logic       rst = 0, en = 0, d_valid = 0, flush = 0;
  logic [7:0] d = '0;
  logic [7:0] q, q1;
  logic       q_valid, q1_valid;
  logic [2:0] occupancy;
  logic [0:0] occupancy1;
  int tests = 0, fails = 0;
  logic [7:0] md [$];
  logic       mv [$];
  logic [7:0] m1d;
  logic       m1v;

  always #5 clk = ~clk;

  dff_delay_line #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .d(d), .d_valid(d_valid), .flush(flush),
    .q(q), .q_valid(q_valid), .occupancy(occupancy));

  dff_delay_line #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h5A)) dut1 (
    .clk(clk), .rst(rst), .en(en), .d(d), .d_valid(d_valid), .flush(flush),
    .q(q1), .q_valid(q1_valid), .occupancy(occupancy1));

  function automatic logic [11:0] exp4();
    int n = 0;
    foreach (mv[i]) n += int'(mv[i]);
    return {md[$], mv[$], 3'(n)};
  endfunction

  // Model: the last four enabled-edge entries, newest first; a flush just marks history invalid.
  task automatic step(input logic r, input logic f, input logic e, input logic dv, input logic [7:0] dd);
    rst = r; flush = f; en = e; d_valid = dv; d = dd;
    @(posedge clk);
    if (r) begin
      md.delete(); mv.delete();
      repeat (4) begin md.push_back(8'h00); mv.push_back(1'b0); end
      m1d = 8'h5A; m1v = 1'b0;
    end else if (f) begin
      foreach (mv[i]) mv[i] = 1'b0;
      m1v = 1'b0;
    end else if (e) begin
      md.push_front(dd); mv.push_front(dv);
      void'(md.pop_back()); void'(mv.pop_back());
      m1d = dd; m1v = dv;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1, 1, 8'hA5);
      tests++;
      if ({q, q_valid, occupancy} !== 12'h000) begin
        fails++; $display("FAIL reset edge%0d: got q=%h v=%b occ=%0d, want 00/0/0", k, q, q_valid, occupancy);
      end
    end
    rst = 0;
    #2;
    tests++;
    if ({q, q_valid, occupancy} !== 12'h000) begin
      fails++; $display("FAIL reset_release_between_edges: got q=%h v=%b occ=%0d, want 00/0/0", q, q_valid, occupancy);
    end
  endtask

  task automatic test_fill();
    logic [2:0] occ_tab [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 1, 1, 8'(k));
      tests++;
      if (occupancy !== occ_tab[k-1] || {q, q_valid, occupancy} !== exp4()) begin
        fails++; $display("FAIL fill edge%0d: got q=%h v=%b occ=%0d, want occ=%0d model=%h", k, q, q_valid, occupancy, occ_tab[k-1], exp4());
      end
    end
    tests++;
    if (q !== 8'h02 || q_valid !== 1'b1) begin
      fails++; $display("FAIL fill_latency: got q=%h v=%b, want 02/1", q, q_valid);
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 1'($urandom), 8'($urandom));
      tests++;
      if ({q, q_valid, occupancy} !== {8'h02, 1'b1, 3'd4}) begin
        fails++; $display("FAIL stall cyc%0d: got q=%h v=%b occ=%0d, want 02/1/4", k, q, q_valid, occupancy);
      end
    end
    step(0, 0, 1, 1, 8'($urandom));
    tests++;
    if ({q, q_valid, occupancy} !== {8'h03, 1'b1, 3'd4}) begin
      fails++; $display("FAIL stall_resume: got q=%h v=%b occ=%0d, want 03/1/4", q, q_valid, occupancy);
    end
  endtask

  task automatic test_bubbles();
    logic [7:0] dt [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic       vt [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int peak = 0;
    step(1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, k < 4 ? vt[k] : 1'b0, k < 4 ? dt[k] : 8'($urandom));
      if (int'(occupancy) > peak) peak = int'(occupancy);
      tests++;
      if ({q, q_valid, occupancy} !== exp4() || (k >= 3 && k < 7 && {q, q_valid} !== {dt[k-3], vt[k-3]})) begin
        fails++; $display("FAIL bubble edge%0d: got q=%h v=%b occ=%0d, model=%h", k+1, q, q_valid, occupancy, exp4());
      end
    end
    tests++;
    if (peak != 2 || occupancy !== 3'd0) begin
      fails++; $display("FAIL bubble_occ: got peak=%0d final=%0d, want 2/0", peak, occupancy);
    end
  endtask

  task automatic test_flush();
    for (int k = 1; k <= 7; k++) step(0, 0, 1, 1, 8'(k));
    tests++;
    if ({q, q_valid, occupancy} !== {8'h04, 1'b1, 3'd4}) begin
      fails++; $display("FAIL flush_prefill: got q=%h v=%b occ=%0d, want 04/1/4", q, q_valid, occupancy);
    end
    step(0, 1, 1, 1, 8'hFF);
    tests++;
    if ({q, q_valid, occupancy} !== {8'h04, 1'b0, 3'd0} || {q, q_valid, occupancy} !== exp4()) begin
      fails++; $display("FAIL flush_edge: got q=%h v=%b occ=%0d, want 04/0/0", q, q_valid, occupancy);
    end
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 1, 0, 8'($urandom_range(0, 254)));
      tests++;
      if (q === 8'hFF || q_valid !== 1'b0 || occupancy !== 3'd0 || {q, q_valid, occupancy} !== exp4()) begin
        fails++; $display("FAIL flush_drain edge%0d: got q=%h v=%b occ=%0d, model=%h", k, q, q_valid, occupancy, exp4());
      end
    end
  endtask

  task automatic test_priority();
    step(0, 0, 1, 1, 8'h77);
    step(1, 1, 1, 1, 8'hEE);
    tests++;
    if ({q, q_valid, occupancy} !== 12'h000 || {q1, q1_valid, occupancy1} !== {8'h5A, 1'b0, 1'b0}) begin
      fails++; $display("FAIL priority_rst: got q=%h v=%b occ=%0d q1=%h v1=%b occ1=%0d, want 00/0/0 5a/0/0",
                        q, q_valid, occupancy, q1, q1_valid, occupancy1);
    end
  endtask

  task automatic test_depth1();
    step(0, 0, 1, 1, 8'h3C);
    tests++;
    if ({q1, q1_valid, occupancy1} !== {8'h3C, 1'b1, 1'b1}) begin
      fails++; $display("FAIL depth1_follow: got q1=%h v1=%b occ1=%0d, want 3c/1/1", q1, q1_valid, occupancy1);
    end
    step(0, 0, 1, 0, 8'hC3);
    tests++;
    if ({q1, q1_valid, occupancy1} !== {8'hC3, 1'b0, 1'b0}) begin
      fails++; $display("FAIL depth1_bubble: got q1=%h v1=%b occ1=%0d, want c3/0/0", q1, q1_valid, occupancy1);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
           1'($urandom), 8'($urandom));
      tests++;
      if ({q, q_valid, occupancy} !== exp4() || {q1, q1_valid, occupancy1} !== {m1d, m1v, m1v}) begin
        fails++; bad++;
        if (bad < 10) $display("FAIL random cyc%0d: got %h/%h, want %h/%h", k,
                               {q, q_valid, occupancy}, {q1, q1_valid, occupancy1}, exp4(), {m1d, m1v, m1v});
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill();
    test_stall();
    test_bubbles();
    test_flush();
    test_priority();
    test_depth1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
